// File: rtl/cla_pkg.sv
// ============================================================================
// Module   : cla_pkg
// Purpose  : Shared constants, types and helpers for the pipelined CLA adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cla_pkg;

    localparam int CLA_GROUP_W = 4;

    // Bits handled by each pipeline slice.
    function automatic int cla_slice_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Group generate / propagate pair.
    typedef struct packed {
        logic g;
        logic p;
    } cla_gp_t;

endpackage : cla_pkg

`default_nettype wire

// File: rtl/cla_group.sv
// ============================================================================
// Module   : cla_group
// Purpose  : Combinational 4-bit carry-look-ahead group with group G/P output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_group
    import cla_pkg::*;
(
    input  logic [CLA_GROUP_W-1:0] a,
    input  logic [CLA_GROUP_W-1:0] b,
    input  logic                   c_in,
    output logic [CLA_GROUP_W-1:0] s,
    output logic                   c_out,
    output cla_gp_t                gp
);

    logic [CLA_GROUP_W-1:0] w_g;
    logic [CLA_GROUP_W-1:0] w_p;
    logic [CLA_GROUP_W-1:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Every internal carry is a flat sum-of-products of c_in, no ripple.
    assign w_c[0] = c_in;
    assign w_c[1] = w_g[0] | (w_p[0] & c_in);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & c_in);

    assign gp.g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign gp.p = &w_p;

    assign c_out = gp.g | (gp.p & c_in);
    assign s     = w_p ^ w_c;

endmodule : cla_group

`default_nettype wire

// File: rtl/cla_pipe_adder.sv
// ============================================================================
// Module   : cla_pipe_adder
// Purpose  : WIDTH-bit adder split into STAGES skewed CLA slices with a
//            valid/ready handshake. Optional CLA_PIPE_OVF_EN adds port ovf.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out
`ifdef CLA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SLICE_W = cla_slice_w(WIDTH, STAGES);
    localparam int N_GRP   = SLICE_W / CLA_GROUP_W;

    // Stage registers: stage k holds finished sum bits below (k+1)*SLICE_W
    // and the untouched operands for the slices still to come.
    logic             r_v   [STAGES];
    logic             r_c   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];

    // Per-stage inputs, either from the ports or from the previous stage.
    logic             w_src_v   [STAGES];
    logic             w_src_c   [STAGES];
    logic [WIDTH-1:0] w_src_a   [STAGES];
    logic [WIDTH-1:0] w_src_b   [STAGES];
    logic [WIDTH-1:0] w_src_sum [STAGES];

    logic [SLICE_W-1:0] w_slice_s [STAGES];
    logic               w_slice_c [STAGES];
    logic [WIDTH-1:0]   w_new_sum [STAGES];

    // w_adv[k]: stage k loads this cycle; w_adv[STAGES] is the consumer.
    logic w_adv [STAGES+1];

    assign w_adv[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic    w_cc         [N_GRP+1];
        cla_gp_t w_gp_unused  [N_GRP];

        if (k == 0) begin : g_head
            assign w_src_v[k]   = in_valid;
            assign w_src_c[k]   = c_in;
            assign w_src_a[k]   = a;
            assign w_src_b[k]   = b;
            assign w_src_sum[k] = '0;
        end else begin : g_body
            assign w_src_v[k]   = r_v[k-1];
            assign w_src_c[k]   = r_c[k-1];
            assign w_src_a[k]   = r_a[k-1];
            assign w_src_b[k]   = r_b[k-1];
            assign w_src_sum[k] = r_sum[k-1];
        end

        // A bubble always loads, so holes in the pipe close up on their own.
        assign w_adv[k] = !r_v[k] || w_adv[k+1];

        assign w_cc[0] = w_src_c[k];

        for (genvar j = 0; j < N_GRP; j++) begin : g_grp
            cla_group u_grp (
                .a     (w_src_a[k][k*SLICE_W + j*CLA_GROUP_W +: CLA_GROUP_W]),
                .b     (w_src_b[k][k*SLICE_W + j*CLA_GROUP_W +: CLA_GROUP_W]),
                .c_in  (w_cc[j]),
                .s     (w_slice_s[k][j*CLA_GROUP_W +: CLA_GROUP_W]),
                .c_out (w_cc[j+1]),
                .gp    (w_gp_unused[j])
            );
        end

        assign w_slice_c[k] = w_cc[N_GRP];
        // Bits above the completed range of w_src_sum are always zero.
        assign w_new_sum[k] = w_src_sum[k] | (WIDTH'(w_slice_s[k]) << (k*SLICE_W));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v[k]   <= 1'b0;
                r_c[k]   <= 1'b0;
                r_sum[k] <= '0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
            end else if (w_adv[k]) begin
                r_v[k] <= w_src_v[k];
                if (w_src_v[k]) begin
                    r_c[k]   <= w_slice_c[k];
                    r_sum[k] <= w_new_sum[k];
                    r_a[k]   <= w_src_a[k];
                    r_b[k]   <= w_src_b[k];
                end
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_v[STAGES-1];
    assign s         = r_sum[STAGES-1];
    assign c_out     = r_c[STAGES-1];

`ifdef CLA_PIPE_OVF_EN
    logic w_msb_cin;
    logic w_ovf_next;
    logic r_ovf;

    // Carry into the MSB recovered from a^b^s at that bit.
    assign w_msb_cin  = w_src_a[STAGES-1][WIDTH-1] ^ w_src_b[STAGES-1][WIDTH-1]
                      ^ w_slice_s[STAGES-1][SLICE_W-1];
    assign w_ovf_next = w_msb_cin ^ w_slice_c[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_adv[STAGES-1] && w_src_v[STAGES-1]) begin
            r_ovf <= w_ovf_next;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule : cla_pipe_adder

`default_nettype wire
